// File: rtl/da_fir_pkg.sv
// rtl/da_fir_pkg.sv - shared types and defaults for the serial operand path
package da_fir_pkg;

  typedef enum logic [0:0] {
    FEED_IDLE  = 1'b0,
    FEED_SHIFT = 1'b1
  } feed_state_t;

  localparam int DA_W   = 8;
  localparam int DA_EXT = 1;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-load right-shift register with MSB hold
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sr;

  // Holding the MSB while shifting makes bit 0 carry the sign once the word is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-1], sr[W-1:1]};
    end
  end

  assign dout = sr[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - streams operand pairs LSB-first into the bit-serial adder
module serial_operand_feeder
  import da_fir_pkg::*;
#(
  parameter int W   = DA_W,
  parameter int EXT = DA_EXT
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         sub_in,
  output logic         A,
  output logic         B,
  output logic         Ci,
  output logic         bit_valid,
  output logic         first,
  output logic         last
);

  localparam int N  = W + EXT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  feed_state_t   state;
  logic [CW-1:0] cnt;
  logic          sub_q;
  logic          shifting;
  logic          accept;
  logic          sa_bit;
  logic          sb_bit;

  assign shifting = (state == FEED_SHIFT);
  assign last     = shifting && (cnt == LAST_CNT);
  assign first    = shifting && (cnt == '0);
  assign in_ready = !Rst && (!shifting || last);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= FEED_IDLE;
      cnt   <= '0;
      sub_q <= 1'b0;
    end else if (accept) begin
      state <= FEED_SHIFT;
      cnt   <= '0;
      sub_q <= sub_in;
    end else if (shifting) begin
      if (last) begin
        state <= FEED_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // B is stored pre-inverted for subtraction; the +1 arrives as Ci on bit 0.
  piso_shreg #(.W(W)) u_sa (
    .clk   (clk),
    .rst   (Rst),
    .load  (accept),
    .shift (shifting),
    .din   (a_in),
    .dout  (sa_bit)
  );

  piso_shreg #(.W(W)) u_sb (
    .clk   (clk),
    .rst   (Rst),
    .load  (accept),
    .shift (shifting),
    .din   (b_in ^ {W{sub_in}}),
    .dout  (sb_bit)
  );

  assign A         = shifting && sa_bit;
  assign B         = shifting && sb_bit;
  assign Ci        = first && sub_q;
  assign bit_valid = shifting;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - directed bench for serial_operand_feeder
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, v2, v3;
  logic [3:0] a_in, b_in;
  logic [1:0] a3, b3;
  logic       sub_in;

  logic r1, A1, B1, C1, bv1, f1, l1;
  logic r2, A2, B2, C2, bv2, f2, l2;
  logic r3, A3, B3, C3, bv3, f3, l3;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.W(4), .EXT(1)) dut1 (
    .clk(clk), .Rst(rst), .in_valid(v1), .in_ready(r1), .a_in(a_in), .b_in(b_in),
    .sub_in(sub_in), .A(A1), .B(B1), .Ci(C1), .bit_valid(bv1), .first(f1), .last(l1)
  );

  serial_operand_feeder #(.W(4), .EXT(2)) dut2 (
    .clk(clk), .Rst(rst), .in_valid(v2), .in_ready(r2), .a_in(a_in), .b_in(b_in),
    .sub_in(sub_in), .A(A2), .B(B2), .Ci(C2), .bit_valid(bv2), .first(f2), .last(l2)
  );

  serial_operand_feeder #(.W(2), .EXT(0)) dut3 (
    .clk(clk), .Rst(rst), .in_valid(v3), .in_ready(r3), .a_in(a3), .b_in(b3),
    .sub_in(sub_in), .A(A3), .B(B3), .Ci(C3), .bit_valid(bv3), .first(f3), .last(l3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ext_bit(input logic [3:0] w, input int i);
    return (i < 4) ? w[i] : w[3];
  endfunction

  // Walks one 5-bit frame of dut1 and runs the downstream serial adder on it.
  task automatic frame1(input string tag, input logic [4:0] ea, input logic [4:0] eb,
                        input logic ci, input logic [4:0] esum);
    logic       c;
    logic [4:0] sum;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_valid"}, bv1, 1'b1);
      chk({tag, "_A"}, A1, ea[i]);
      chk({tag, "_B"}, B1, eb[i]);
      chk({tag, "_Ci"}, C1, (i == 0) ? ci : 1'b0);
      chk({tag, "_first"}, f1, i == 0);
      chk({tag, "_last"}, l1, i == 4);
      chk({tag, "_ready"}, r1, i == 4);
      c      = f1 ? C1 : c;
      sum[i] = A1 ^ B1 ^ c;
      c      = (A1 & B1) | (A1 & c) | (B1 & c);
      tick();
    end
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_idle_valid"}, bv1, 1'b0);
    chk({tag, "_idle_ready"}, r1, 1'b1);
  endtask

  initial begin
    logic       c;
    logic [5:0] sum6;
    logic [3:0] wa [3];
    logic [3:0] wb [3];

    rst = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
    a_in = 4'h3; b_in = 4'h5; a3 = 2'b01; b3 = 2'b10; sub_in = 1'b0;

    // reset held three clocks with in_valid asserted
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", r1, 1'b0);
      chk("rst_valid", bv1, 1'b0);
      chk("rst_outs", {A1, B1, C1, f1, l1}, 5'b0);
      chk("rst_dut2", {r2, bv2, A2, B2}, 4'b0);
    end
    rst = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    #1;
    chk("rel_ready", r1, 1'b1);
    tick();
    chk("rel_no_accept", bv1, 1'b0);
    chk("rel_no_accept3", bv3, 1'b0);

    // add 3 + 5
    a_in = 4'b0011; b_in = 4'b0101; sub_in = 1'b0; v1 = 1'b1;
    tick();
    v1 = 1'b0; a_in = 4'hF; b_in = 4'hF; sub_in = 1'b1;
    frame1("add", 5'b00011, 5'b00101, 1'b0, 5'b01000);

    // subtract 3 - 5
    a_in = 4'b0011; b_in = 4'b0101; sub_in = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0; a_in = 4'h0; b_in = 4'h0; sub_in = 1'b0;
    frame1("sub", 5'b00011, 5'b11010, 1'b1, 5'b11110);

    // back-to-back: three words with in_valid held high
    wa[0] = 4'h1; wb[0] = 4'h2;
    wa[1] = 4'hD; wb[1] = 4'h7;
    wa[2] = 4'h6; wb[2] = 4'h8;
    sub_in = 1'b0; a_in = wa[0]; b_in = wb[0]; v1 = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("b2b_valid", bv1, 1'b1);
      chk("b2b_first", f1, (i % 5) == 0);
      chk("b2b_last", l1, (i % 5) == 4);
      chk("b2b_ready", r1, (i % 5) == 4);
      chk("b2b_A", A1, ext_bit(wa[i / 5], i % 5));
      chk("b2b_B", B1, ext_bit(wb[i / 5], i % 5));
      if (i == 4 || i == 9) begin
        a_in = wa[i / 5 + 1];
        b_in = wb[i / 5 + 1];
      end else if ((i % 5) == 0) begin
        a_in = 4'hA;
        b_in = 4'h5;
      end
      if (i == 14) v1 = 1'b0;
      tick();
    end
    chk("b2b_end_valid", bv1, 1'b0);

    // sign extension on dut2: -8 + -1 over a 6-bit frame
    a_in = 4'b1000; b_in = 4'b1111; sub_in = 1'b0; v2 = 1'b1;
    tick();
    v2 = 1'b0; a_in = 4'h0; b_in = 4'h0;
    c = 1'b0; sum6 = '0;
    for (int i = 0; i < 6; i++) begin
      chk("sx_valid", bv2, 1'b1);
      chk("sx_A", A2, (i >= 3));
      chk("sx_B", B2, 1'b1);
      chk("sx_first", f2, i == 0);
      chk("sx_last", l2, i == 5);
      c       = f2 ? C2 : c;
      sum6[i] = A2 ^ B2 ^ c;
      c       = (A2 & B2) | (A2 & c) | (B2 & c);
      tick();
    end
    chk("sx_sum", sum6, 6'b110111);
    chk("sx_idle", bv2, 1'b0);

    // minimum frame on dut3 (W=2, EXT=0)
    a3 = 2'b01; b3 = 2'b10; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("min_b0", {bv3, f3, l3, A3, B3}, 5'b11010);
    tick();
    chk("min_b1", {bv3, f3, l3, A3, B3}, 5'b10101);
    tick();
    chk("min_idle", bv3, 1'b0);

    // asynchronous reset at bit 2 of a frame
    a_in = 4'b0101; b_in = 4'b0100; sub_in = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0; sub_in = 1'b0;
    tick();
    tick();
    chk("mid_pre_A", A1, 1'b1);
    chk("mid_pre_B", B1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_outs", {A1, B1, C1, bv1, f1, l1}, 6'b0);
    chk("mid_async_ready", r1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", r1, 1'b1);
    tick();
    chk("mid_no_remnant", bv1, 1'b0);
    a_in = 4'b0110; b_in = 4'b0001; sub_in = 1'b0; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    frame1("mid_new", 5'b00110, 5'b00001, 1'b0, 5'b00111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
